// File: rtl/lc3_pkg.sv
// Shared LC-3 constants for the operate-instruction sequencer: opcodes, ALU
// function codes, FSM state encoding and the condition-code helper.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

  // Condition codes are one-hot: negative wins on bit 15, zero otherwise checked.
  function automatic logic [2:0] nzp_of(input logic [15:0] value);
    if (value[15])          return 3'b100;
    else if (value == '0)   return 3'b010;
    else                    return 3'b001;
  endfunction

endpackage

// File: rtl/lc3_op_decode.sv
// Combinational decode of LC-3 operate instructions (ADD, AND, NOT) into a
// legality flag and ALU controls.
module lc3_op_decode
  import lc3_pkg::*;
(
  input  logic [15:0] instr,
  output logic        legal,
  output alu_op_e     alu_opcode,
  output logic        sr2mux
);

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    legal      = 1'b0;
    alu_opcode = ALU_PASS;
    sr2mux     = 1'b0;
    case (instr[15:12])
      OP_ADD: begin
        legal      = 1'b1;
        alu_opcode = ALU_ADD;
        sr2mux     = instr[5];
      end
      OP_AND: begin
        legal      = 1'b1;
        alu_opcode = ALU_AND;
        sr2mux     = instr[5];
      end
      OP_NOT: begin
        // NOT is only well-formed with all-ones in the low six bits.
        legal      = (instr[5:0] == 6'b111111);
        alu_opcode = ALU_NOT;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lc3_op_sequencer.sv
// Four-state sequencer for LC-3 operate instructions: fetch operands from an
// external register file, drive an external ALU, write back and set NZP.
module lc3_op_sequencer
  import lc3_pkg::*;
#(
  parameter logic [2:0] NZP_RST = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  sr1_addr,
  output logic [2:0]  sr2_addr,
  input  logic [15:0] sr1_data,
  input  logic [15:0] sr2_data,
  output logic [15:0] alu_operand0,
  output logic [15:0] alu_operand2,
  output logic [4:0]  alu_imm5,
  output logic        alu_sr2mux,
  output logic [1:0]  alu_opcode,
  input  logic [15:0] alu_result,
  output logic        rf_we,
  output logic [2:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [15:0] ir_q;
  logic [15:0] op_sr1_q, op_sr2_q, res_q;
  alu_op_e     alu_op_q;
  logic        sr2mux_q;
  logic [2:0]  nzp_q;

  logic        dec_legal;
  alu_op_e     dec_op;
  logic        dec_sr2mux;

  lc3_op_decode u_decode (
    .instr      (ir_q),
    .legal      (dec_legal),
    .alu_opcode (dec_op),
    .sr2mux     (dec_sr2mux)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (instr_valid) state_d = S_READ;
      S_READ: state_d = dec_legal ? S_EXEC : S_IDLE;
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ir_q     <= '0;
      op_sr1_q <= '0;
      op_sr2_q <= '0;
      res_q    <= '0;
      alu_op_q <= ALU_PASS;
      sr2mux_q <= 1'b0;
      nzp_q    <= NZP_RST;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: if (instr_valid) ir_q <= instr;
        S_READ: if (dec_legal) begin
          // ALU controls are latched here and stay put until the next decode.
          op_sr1_q <= sr1_data;
          op_sr2_q <= sr2_data;
          alu_op_q <= dec_op;
          sr2mux_q <= dec_sr2mux;
        end
        S_EXEC: res_q <= alu_result;
        S_WB:   nzp_q <= nzp_of(res_q);
        default: ;
      endcase
    end
  end

  // NOT reads its source through the SR2 port because the ALU inverts that path.
  always_comb begin
    sr1_addr = '0;
    sr2_addr = '0;
    if (state_q == S_READ) begin
      sr1_addr = ir_q[8:6];
      sr2_addr = (dec_op == ALU_NOT) ? ir_q[8:6] : ir_q[2:0];
    end
  end

  assign instr_ready  = (state_q == S_IDLE);
  assign illegal      = (state_q == S_READ) && !dec_legal;
  assign rf_we        = (state_q == S_WB);
  assign done         = (state_q == S_WB);
  assign rf_waddr     = (state_q == S_WB) ? ir_q[11:9] : 3'd0;
  assign rf_wdata     = res_q;
  assign nzp          = nzp_q;
  assign alu_operand0 = op_sr2_q;
  assign alu_operand2 = op_sr1_q;
  assign alu_imm5     = ir_q[4:0];
  assign alu_sr2mux   = sr2mux_q;
  assign alu_opcode   = alu_op_q;

endmodule

// File: tb/tb_lc3_op_sequencer.sv
// Directed bench for lc3_op_sequencer with a behavioural register file and ALU
// wrapped around the DUT; expected values are hand-computed constants.
module tb_lc3_op_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [2:0]  sr1_addr, sr2_addr;
  logic [15:0] sr1_data, sr2_data;
  logic [15:0] alu_operand0, alu_operand2;
  logic [4:0]  alu_imm5;
  logic        alu_sr2mux;
  logic [1:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [2:0]  nzp;
  logic        done;
  logic        illegal;

  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [15:0] pre_data;
  logic [15:0] regs [8];

  int n_checks = 0;
  int n_errors = 0;

  lc3_op_sequencer #(.NZP_RST(3'b010)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .sr1_addr     (sr1_addr),
    .sr2_addr     (sr2_addr),
    .sr1_data     (sr1_data),
    .sr2_data     (sr2_data),
    .alu_operand0 (alu_operand0),
    .alu_operand2 (alu_operand2),
    .alu_imm5     (alu_imm5),
    .alu_sr2mux   (alu_sr2mux),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .nzp          (nzp),
    .done         (done),
    .illegal      (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: bench preload port takes priority over the DUT write port.
  always @(posedge clk) begin
    if (pre_we)     regs[pre_addr] <= pre_data;
    else if (rf_we) regs[rf_waddr] <= rf_wdata;
  end
  assign sr1_data = regs[sr1_addr];
  assign sr2_data = regs[sr2_addr];

  // External ALU with sign-extended immediate on the SR2 path.
  logic [15:0] alu_b;
  always_comb begin
    alu_b = alu_sr2mux ? {{11{alu_imm5[4]}}, alu_imm5} : alu_operand0;
    case (alu_opcode)
      2'b00:   alu_result = alu_operand2 + alu_b;
      2'b01:   alu_result = alu_operand2 & alu_b;
      2'b10:   alu_result = ~alu_operand0;
      default: alu_result = alu_operand0;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    instr = w; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    step(); step();

    check("rst_ready",   {15'd0, instr_ready}, 16'd1);
    check("rst_nzp",     {13'd0, nzp},         16'h0002);
    check("rst_rf_we",   {15'd0, rf_we},       16'd0);
    check("rst_done",    {15'd0, done},        16'd0);
    check("rst_illegal", {15'd0, illegal},     16'd0);
    check("rst_opcode",  {14'd0, alu_opcode},  16'h0003);
    check("rst_sr2mux",  {15'd0, alu_sr2mux},  16'd0);
    check("rst_sr1addr", {13'd0, sr1_addr},    16'd0);
    check("rst_sr2addr", {13'd0, sr2_addr},    16'd0);
    check("rst_waddr",   {13'd0, rf_waddr},    16'd0);
    check("rst_op0",     alu_operand0,         16'd0);
    check("rst_op2",     alu_operand2,         16'd0);
    check("rst_wdata",   rf_wdata,             16'd0);
    rst = 1'b0;

    preload(3'd2, 16'h0005);
    preload(3'd3, 16'h0007);
    preload(3'd5, 16'h00FF);
    preload(3'd6, 16'h7FFF);
    preload(3'd7, 16'h0001);

    // ADD R1,R2,R3
    issue(16'h1283);
    check("add_read_ready", {15'd0, instr_ready}, 16'd0);
    check("add_read_ill",   {15'd0, illegal},     16'd0);
    check("add_sr1addr",    {13'd0, sr1_addr},    16'd2);
    check("add_sr2addr",    {13'd0, sr2_addr},    16'd3);
    check("add_read_we",    {15'd0, rf_we},       16'd0);
    step();
    check("add_op2",        alu_operand2,         16'h0005);
    check("add_op0",        alu_operand0,         16'h0007);
    check("add_opcode",     {14'd0, alu_opcode},  16'd0);
    check("add_sr2mux",     {15'd0, alu_sr2mux},  16'd0);
    check("add_exec_we",    {15'd0, rf_we},       16'd0);
    step();
    check("add_wb_we",      {15'd0, rf_we},       16'd1);
    check("add_waddr",      {13'd0, rf_waddr},    16'd1);
    check("add_wdata",      rf_wdata,             16'h000C);
    check("add_done",       {15'd0, done},        16'd1);
    step();
    check("add_post_we",    {15'd0, rf_we},       16'd0);
    check("add_post_done",  {15'd0, done},        16'd0);
    check("add_nzp",        {13'd0, nzp},         16'h0001);
    check("add_post_ready", {15'd0, instr_ready}, 16'd1);
    check("add_hold_op",    {14'd0, alu_opcode},  16'd0);

    // ADD R0,R6,R7: 0x7FFF+1 wraps to 0x8000 -> negative
    issue(16'h1187);
    step(); step();
    check("wrap_wdata",     rf_wdata,             16'h8000);
    check("wrap_waddr",     {13'd0, rf_waddr},    16'd0);
    step();
    check("wrap_nzp",       {13'd0, nzp},         16'h0004);

    // ADD R1,R1,#-1 with R1=1 -> zero
    preload(3'd1, 16'h0001);
    issue(16'h127F);
    check("imm_sr1addr",    {13'd0, sr1_addr},    16'd1);
    step();
    check("imm_sr2mux",     {15'd0, alu_sr2mux},  16'd1);
    check("imm_imm5",       {11'd0, alu_imm5},    16'h001F);
    check("imm_op2",        alu_operand2,         16'h0001);
    step();
    check("imm_wdata",      rf_wdata,             16'h0000);
    check("imm_waddr",      {13'd0, rf_waddr},    16'd1);
    step();
    check("imm_nzp",        {13'd0, nzp},         16'h0002);

    // NOT R4,R5
    issue(16'h997F);
    check("not_sr2addr",    {13'd0, sr2_addr},    16'd5);
    step();
    check("not_sr2mux",     {15'd0, alu_sr2mux},  16'd0);
    check("not_opcode",     {14'd0, alu_opcode},  16'h0002);
    check("not_op0",        alu_operand0,         16'h00FF);
    step();
    check("not_wdata",      rf_wdata,             16'hFF00);
    check("not_waddr",      {13'd0, rf_waddr},    16'd4);
    step();
    check("not_nzp",        {13'd0, nzp},         16'h0004);

    // Illegal opcode 0x0000
    issue(16'h0000);
    check("ill0_pulse",     {15'd0, illegal},     16'd1);
    check("ill0_we",        {15'd0, rf_we},       16'd0);
    check("ill0_ready_t1",  {15'd0, instr_ready}, 16'd0);
    step();
    check("ill0_clear",     {15'd0, illegal},     16'd0);
    check("ill0_ready_t2",  {15'd0, instr_ready}, 16'd1);
    check("ill0_we_t2",     {15'd0, rf_we},       16'd0);
    check("ill0_nzp",       {13'd0, nzp},         16'h0004);

    // NOT with malformed low bits
    issue(16'h9940);
    check("ill9_pulse",     {15'd0, illegal},     16'd1);
    check("ill9_we",        {15'd0, rf_we},       16'd0);
    step();
    check("ill9_ready_t2",  {15'd0, instr_ready}, 16'd1);
    check("ill9_we_t2",     {15'd0, rf_we},       16'd0);
    check("ill9_nzp",       {13'd0, nzp},         16'h0004);

    // Back-to-back: valid held high; a busy-time offer of 0x0000 must be ignored
    instr = 16'h1283; instr_valid = 1'b1;
    step();
    check("b2b_t1_ready",   {15'd0, instr_ready}, 16'd0);
    instr = 16'h0000;
    step();
    check("b2b_t2_ready",   {15'd0, instr_ready}, 16'd0);
    check("b2b_t2_ill",     {15'd0, illegal},     16'd0);
    step();
    check("b2b_t3_we",      {15'd0, rf_we},       16'd1);
    check("b2b_t3_wdata",   rf_wdata,             16'h000C);
    instr = 16'h1283;
    step();
    check("b2b_t4_ready",   {15'd0, instr_ready}, 16'd1);
    check("b2b_t4_we",      {15'd0, rf_we},       16'd0);
    step();
    instr_valid = 1'b0;
    check("b2b_t5_ready",   {15'd0, instr_ready}, 16'd0);
    check("b2b_t5_sr1addr", {13'd0, sr1_addr},    16'd2);
    step(); step();
    check("b2b_2nd_we",     {15'd0, rf_we},       16'd1);
    check("b2b_2nd_wdata",  rf_wdata,             16'h000C);
    step();
    check("b2b_nzp",        {13'd0, nzp},         16'h0001);

    // Reset in EXEC of ADD R0,R0,#1, with a simultaneous offer
    issue(16'h1021);
    step();
    check("rexec_opcode",   {14'd0, alu_opcode},  16'd0);
    rst = 1'b1; instr = 16'h1021; instr_valid = 1'b1;
    step();
    check("rexec_ready",    {15'd0, instr_ready}, 16'd1);
    check("rexec_we",       {15'd0, rf_we},       16'd0);
    check("rexec_nzp",      {13'd0, nzp},         16'h0002);
    check("rexec_opc_rst",  {14'd0, alu_opcode},  16'h0003);
    check("rexec_op2",      alu_operand2,         16'd0);
    rst = 1'b0; instr_valid = 1'b0;
    step();
    check("rexec_post_we",  {15'd0, rf_we},       16'd0);
    check("rexec_post_rdy", {15'd0, instr_ready}, 16'd1);
    check("rexec_post_done",{15'd0, done},        16'd0);
    step();
    check("rexec_late_we",  {15'd0, rf_we},       16'd0);
    check("rexec_late_nzp", {13'd0, nzp},         16'h0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
